// File: rtl/rtc_lectura_hora.sv
// Bus sequencer that reads seconds, minutes and hours from a multiplexed
// address/data RTC chip and presents them as bytes to the time block.
module rtc_lectura_hora #(
    parameter int unsigned T_FASE   = 4,
    parameter logic [7:0]  DIR_SEG  = 8'h21,
    parameter logic [7:0]  DIR_MIN  = 8'h22,
    parameter logic [7:0]  DIR_HORA = 8'h23
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       inicio,
    input  logic [7:0] dato_rtc_in,
    output logic [7:0] AD_out,
    output logic       AD_oe,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D_n,
    output logic [7:0] OUT_segh,
    output logic [7:0] OUT_minh,
    output logic [7:0] OUT_horah,
    output logic [3:0] Selec_Demux_DD,
    output logic       READ,
    output logic       listo,
    output logic       error_bcd
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        HOLD1,
        DATA,
        HOLD2,
        FIN
    } state_t;

    localparam logic [1:0] IDX_SEG  = 2'd0;
    localparam logic [1:0] IDX_MIN  = 2'd1;
    localparam logic [1:0] IDX_HORA = 2'd2;
    localparam logic [3:0] LAST     = 4'(T_FASE - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a_d_n_q, a_d_n_d;
    logic       ad_oe_q, ad_oe_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic [3:0] sel_q, sel_d;
    logic       read_q, read_d;
    logic       listo_q, listo_d;
    logic [7:0] seg_q, seg_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hora_q, hora_d;
    logic       err_q, err_d;
    logic [7:0] samp_q, samp_d;
    logic       samp_vld_q, samp_vld_d;
    logic       phase_end;
    logic       samp_bcd_ok;

    assign phase_end   = (cnt_q == LAST);
    assign samp_bcd_ok = (samp_q[7:4] <= 4'd9) && (samp_q[3:0] <= 4'd9);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        read_d     = read_q;
        listo_d    = 1'b0;
        samp_d     = samp_q;
        samp_vld_d = 1'b0;
        seg_d      = seg_q;
        min_d      = min_q;
        hora_d     = hora_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (inicio) begin
                    state_d = ADDR;
                    idx_d   = IDX_SEG;
                    cnt_d   = 4'd0;
                    read_d  = 1'b1;
                end
            end
            ADDR, HOLD1: begin
                if (phase_end) begin
                    cnt_d   = 4'd0;
                    state_d = (state_q == ADDR) ? HOLD1 : DATA;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DATA: begin
                if (phase_end) begin
                    cnt_d      = 4'd0;
                    state_d    = HOLD2;
                    samp_d     = dato_rtc_in;
                    samp_vld_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD2: begin
                if (phase_end) begin
                    cnt_d = 4'd0;
                    if (idx_q == IDX_HORA) begin
                        state_d = FIN;
                        read_d  = 1'b0;
                    end else begin
                        state_d = ADDR;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FIN: begin
                listo_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                read_d  = 1'b0;
            end
        endcase

        // Hours keep their 12/24 and AM/PM flag bits, so no BCD screening.
        if (samp_vld_q) begin
            unique case (idx_q)
                IDX_SEG: begin
                    if (samp_bcd_ok) seg_d = samp_q;
                    else err_d = 1'b1;
                end
                IDX_MIN: begin
                    if (samp_bcd_ok) min_d = samp_q;
                    else err_d = 1'b1;
                end
                default: hora_d = samp_q;
            endcase
        end
    end

    // Bus and selector outputs are decoded from the next state so they
    // are registered yet line up with the state they belong to.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_n_d  = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        sel_d    = 4'd0;

        unique case (state_d)
            ADDR: begin
                cs_n_d  = 1'b0;
                wr_n_d  = 1'b0;
                a_d_n_d = 1'b0;
                ad_oe_d = 1'b1;
                unique case (idx_d)
                    IDX_SEG: ad_out_d = DIR_SEG;
                    IDX_MIN: ad_out_d = DIR_MIN;
                    default: ad_out_d = DIR_HORA;
                endcase
            end
            DATA: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            default: ;
        endcase

        if (state_d == ADDR || state_d == HOLD1 ||
            state_d == DATA || state_d == HOLD2) begin
            sel_d = 4'd5 - {2'b00, idx_d};
        end
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= IDX_SEG;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a_d_n_q    <= 1'b1;
            ad_oe_q    <= 1'b0;
            ad_out_q   <= 8'h00;
            sel_q      <= 4'd0;
            read_q     <= 1'b0;
            listo_q    <= 1'b0;
            seg_q      <= 8'h00;
            min_q      <= 8'h00;
            hora_q     <= 8'h00;
            err_q      <= 1'b0;
            samp_q     <= 8'h00;
            samp_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a_d_n_q    <= a_d_n_d;
            ad_oe_q    <= ad_oe_d;
            ad_out_q   <= ad_out_d;
            sel_q      <= sel_d;
            read_q     <= read_d;
            listo_q    <= listo_d;
            seg_q      <= seg_d;
            min_q      <= min_d;
            hora_q     <= hora_d;
            err_q      <= err_d;
            samp_q     <= samp_d;
            samp_vld_q <= samp_vld_d;
        end
    end

    assign AD_out         = ad_out_q;
    assign AD_oe          = ad_oe_q;
    assign CS_n           = cs_n_q;
    assign RD_n           = rd_n_q;
    assign WR_n           = wr_n_q;
    assign A_D_n          = a_d_n_q;
    assign OUT_segh       = seg_q;
    assign OUT_minh       = min_q;
    assign OUT_horah      = hora_q;
    assign Selec_Demux_DD = sel_q;
    assign READ           = read_q;
    assign listo          = listo_q;
    assign error_bcd      = err_q;

endmodule

// File: doc/rtc_lectura_hora.md
Name: rtc_lectura_hora

Overview:
- Upstream bus sequencer for the time block.
- Reads seconds, minutes and hours from the external address/data-multiplexed RTC chip.
- Presents them as BCD bytes on OUT_segh/OUT_minh/OUT_horah, which the time block takes as IN_segh/IN_minh/IN_horah.
- Drives READ and Selec_Demux_DD so the time block knows which register is being refreshed.

Parameters:
- T_FASE, 4: clock cycles per bus phase (1..15).
- DIR_SEG, 8'h21: RTC address of seconds register.
- DIR_MIN, 8'h22: RTC address of minutes register.
- DIR_HORA, 8'h23: RTC address of hours register.

Ports:
- reloj  input  1  system clock, rising edge.
- resetM  input  1  asynchronous, active-high reset.
- inicio  input  1  one-cycle request to start a read burst.
- dato_rtc_in  input  8  data driven by the RTC on the AD bus.
- AD_out  output  8  address driven onto the AD bus.
- AD_oe  output  1  1 = this block drives the AD bus.
- CS_n  output  1  RTC chip select, active low.
- RD_n  output  1  RTC read strobe, active low.
- WR_n  output  1  RTC write strobe, active low.
- A_D_n  output  1  0 = address phase, 1 = data phase.
- OUT_segh  output  8  last valid BCD seconds.
- OUT_minh  output  8  last valid BCD minutes.
- OUT_horah  output  8  last valid raw hours byte.
- Selec_Demux_DD  output  4  register being read: 5 = seg, 4 = min, 3 = hora, 0 = idle.
- READ  output  1  high for the whole burst.
- listo  output  1  one-cycle pulse at burst end.
- error_bcd  output  1  sticky; a sampled seconds/minutes byte had a nibble > 9.

Behaviour:
- Reset values (applied immediately, asynchronously):
  - CS_n = RD_n = WR_n = A_D_n = 1; AD_oe = 0; AD_out = 0.
  - OUT_* = 8'h00; Selec_Demux_DD = 0; READ = 0; listo = 0; error_bcd = 0.
  - FSM goes to IDLE; phase counter = 0.
- FSM states:
  - IDLE: waits for inicio = 1. Next edge: READ = 1, register index = SEG, go to ADDR.
  - ADDR (T_FASE cycles): CS_n = 0, WR_n = 0, A_D_n = 0, AD_oe = 1, AD_out = register address.
  - HOLD1 (T_FASE): CS_n = 1, WR_n = 1, AD_oe = 0, A_D_n = 1.
  - DATA (T_FASE): CS_n = 0, RD_n = 0, A_D_n = 1, AD_oe = 0. dato_rtc_in is sampled on the last cycle of DATA (phase counter = T_FASE-1).
  - HOLD2 (T_FASE): all strobes inactive. At its end: if index = HORA, go to FIN; else advance index (SEG → MIN → HORA) and go to ADDR.
  - FIN (1 cycle): listo = 1, READ = 0, Selec_Demux_DD = 0; then IDLE.
- Sample handling:
  - Seconds/minutes: the OUT register loads on the edge after sampling only if both nibbles ≤ 9. Otherwise the old value is kept and error_bcd is set.
  - Hours: loaded unchanged (bit7 12/24 flag and bit5 AM/PM are preserved for the F_H logic).
- Selec_Demux_DD holds 5/4/3 from the first ADDR cycle through the last HOLD2 cycle of each register.
- Timing:
  - Burst = 12*T_FASE cycles from ADDR entry to FIN.
  - listo asserts 12*T_FASE+1 cycles after the edge that sampled inicio.
- inicio while not in IDLE: ignored, not queued. inicio in the FIN cycle: ignored.
- Strobe safety: RD_n and WR_n are never low together. AD_oe = 1 only while A_D_n = 0.
- Reset mid-burst: bus released on the same instant. Partially read data is discarded; OUT_* go to 0.
- error_bcd clears only on reset.
- Counter: phase counter width is 4 bits and wraps to 0 at each phase change.

Test Plan:
1. Reset, T_FASE = 4, RTC model returns 8'h45/8'h30/8'h12; pulse inicio → Selec_Demux_DD sequence 5, 4, 3, 0; OUT = 45/30/12; listo pulses once at cycle 49 after inicio; READ high exactly 48 cycles.
2. Bus check during scenario 1:
   - CS_n low only in ADDR/DATA.
   - A_D_n = 0 and AD_out = 21/22/23 during the three ADDR phases.
   - AD_oe never 1 while RD_n = 0.
3. Model returns minutes = 8'h7A → OUT_minh keeps its prior value (8'h30); error_bcd = 1 and stays 1 after a later clean burst.
4. Hours 8'hB2 (12 h mode, PM) → OUT_horah = 8'hB2 unmodified.
5. inicio pulsed again 10 cycles into a burst → no second burst; exactly one listo.
6. resetM asserted during DATA of minutes → CS_n/RD_n = 1 and OUT_* = 0 without waiting for a clock edge; after release, a new inicio completes a normal burst.
